// File: rtl/fetch_pkg.sv
// Shared types for the instruction fetch queue: the buffered {pc, instr} entry and default depth.
`ifndef ADDR_WIDTH
`define ADDR_WIDTH 32
`endif
`ifndef DATA_WIDTH
`define DATA_WIDTH 32
`endif

package fetch_pkg;

  typedef struct packed {
    logic [`ADDR_WIDTH-1:0] pc;
    logic [`DATA_WIDTH-1:0] instr;
  } fetch_entry_t;

  localparam int FETCH_QUEUE_DEPTH_DEFAULT = 4;

endpackage

// File: rtl/fetch_queue_ram.sv
// DEPTH-entry fetch entry store: synchronous write, asynchronous read; contents are never reset.
`ifndef ADDR_WIDTH
`define ADDR_WIDTH 32
`endif
`ifndef DATA_WIDTH
`define DATA_WIDTH 32
`endif

module fetch_queue_ram
  import fetch_pkg::*;
#(
  parameter int DEPTH     = FETCH_QUEUE_DEPTH_DEFAULT,
  parameter int PTR_WIDTH = $clog2(DEPTH)
) (
  input  logic                 clk,
  input  logic                 wr_en,
  input  logic [PTR_WIDTH-1:0] wr_addr,
  input  fetch_entry_t         wr_data,
  input  logic [PTR_WIDTH-1:0] rd_addr,
  output fetch_entry_t         rd_data
);

  fetch_entry_t mem [DEPTH];

  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem[wr_addr] <= wr_data;
    end
  end

  assign rd_data = mem[rd_addr];

endmodule

// File: rtl/i_fetch_queue.sv
// In-order FWFT queue between icache and decode; entries visible one cycle after enqueue, no bypass.
// o_ready/o_valid come from registered occupancy only; flush discards everything and beats enq/deq.
`ifndef ADDR_WIDTH
`define ADDR_WIDTH 32
`endif
`ifndef DATA_WIDTH
`define DATA_WIDTH 32
`endif

module i_fetch_queue
  import fetch_pkg::*;
#(
  parameter  int DEPTH     = FETCH_QUEUE_DEPTH_DEFAULT,
  localparam int PTR_WIDTH = $clog2(DEPTH)
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   i_flush,
  input  logic                   i_valid,
  input  logic [`ADDR_WIDTH-1:0] i_pc,
  input  logic [`DATA_WIDTH-1:0] i_instr,
  output logic                   o_ready,
  output logic                   o_valid,
  output logic [`ADDR_WIDTH-1:0] o_pc,
  output logic [`DATA_WIDTH-1:0] o_instr,
  input  logic                   i_ready,
  output logic [PTR_WIDTH:0]     o_count,
  output logic                   o_almost_full
);

  if (DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0) begin : g_bad_depth
    $error("i_fetch_queue: DEPTH must be a power of two and at least 2");
  end

  localparam logic [PTR_WIDTH:0] FULL_CNT   = DEPTH[PTR_WIDTH:0];
  localparam logic [PTR_WIDTH:0] ALMOST_CNT = FULL_CNT - 1'b1;

  logic [PTR_WIDTH-1:0] head;
  logic [PTR_WIDTH-1:0] tail;
  logic [PTR_WIDTH:0]   count;
  logic [PTR_WIDTH:0]   count_next;
  logic                 enq;
  logic                 deq;
  fetch_entry_t         wr_entry;
  fetch_entry_t         rd_entry;

  assign o_valid       = (count != '0);
  assign o_ready       = (count != FULL_CNT);
  assign o_almost_full = (count >= ALMOST_CNT);
  assign o_count       = count;

  assign enq = i_valid & o_ready & ~i_flush;
  assign deq = o_valid & i_ready & ~i_flush;

  assign count_next = count + {{PTR_WIDTH{1'b0}}, enq} - {{PTR_WIDTH{1'b0}}, deq};

  assign wr_entry.pc    = i_pc;
  assign wr_entry.instr = i_instr;

  // Storage holds stale data after flush/reset, so the head is masked when empty.
  assign o_pc    = o_valid ? rd_entry.pc    : '0;
  assign o_instr = o_valid ? rd_entry.instr : '0;

  fetch_queue_ram #(
    .DEPTH     (DEPTH),
    .PTR_WIDTH (PTR_WIDTH)
  ) u_ram (
    .clk     (clk),
    .wr_en   (enq & rst_n),
    .wr_addr (tail),
    .wr_data (wr_entry),
    .rd_addr (head),
    .rd_data (rd_entry)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      head  <= '0;
      tail  <= '0;
      count <= '0;
    end else if (i_flush) begin
      head  <= '0;
      tail  <= '0;
      count <= '0;
    end else begin
      if (enq) begin
        tail <= tail + 1'b1;
      end
      if (deq) begin
        head <= head + 1'b1;
      end
      count <= count_next;
    end
  end

  a_count_max : assert property (@(posedge clk) disable iff (!rst_n)
    count <= FULL_CNT);
  a_no_underflow : assert property (@(posedge clk) disable iff (!rst_n)
    !(deq && count == '0));
  a_pc_aligned : assert property (@(posedge clk) disable iff (!rst_n)
    o_valid |-> (o_pc[1:0] == 2'b00));

endmodule

// File: tb/tb_i_fetch_queue.sv
// Bench for i_fetch_queue: directed scenarios plus random traffic against a queue-based model.
`ifndef ADDR_WIDTH
`define ADDR_WIDTH 32
`endif
`ifndef DATA_WIDTH
`define DATA_WIDTH 32
`endif

module tb_i_fetch_queue;

  localparam int DEPTH = 4;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        i_flush;
  logic        i_valid;
  logic [31:0] i_pc;
  logic [31:0] i_instr;
  logic        o_ready;
  logic        o_valid;
  logic [31:0] o_pc;
  logic [31:0] o_instr;
  logic        i_ready;
  logic [2:0]  o_count;
  logic        o_almost_full;

  i_fetch_queue #(.DEPTH(DEPTH)) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .i_flush       (i_flush),
    .i_valid       (i_valid),
    .i_pc          (i_pc),
    .i_instr       (i_instr),
    .o_ready       (o_ready),
    .o_valid       (o_valid),
    .o_pc          (o_pc),
    .o_instr       (o_instr),
    .i_ready       (i_ready),
    .o_count       (o_count),
    .o_almost_full (o_almost_full)
  );

  always #5 clk = ~clk;

  int vectors = 0;
  int miscompares = 0;

  logic [31:0] mq_pc[$];
  logic [31:0] mq_instr[$];
  bit          accepted;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Compare outputs against the model mid-cycle, then advance the model at the edge.
  task automatic cycle();
    int sz;
    @(negedge clk);
    sz = mq_pc.size();
    chk("valid", {31'b0, o_valid}, {31'b0, sz != 0});
    chk("ready", {31'b0, o_ready}, {31'b0, sz != DEPTH});
    chk("count", {29'b0, o_count}, sz);
    chk("almost_full", {31'b0, o_almost_full}, {31'b0, sz >= DEPTH - 1});
    chk("head_pc", o_pc, (sz != 0) ? mq_pc[0] : 32'h0);
    chk("head_instr", o_instr, (sz != 0) ? mq_instr[0] : 32'h0);
    @(posedge clk);
    accepted = 1'b0;
    if (!rst_n || i_flush) begin
      mq_pc.delete();
      mq_instr.delete();
    end else begin
      if (i_ready && sz != 0) begin
        void'(mq_pc.pop_front());
        void'(mq_instr.pop_front());
      end
      if (i_valid && sz != DEPTH) begin
        mq_pc.push_back(i_pc);
        mq_instr.push_back(i_instr);
        accepted = 1'b1;
      end
    end
    #1;
  endtask

  task automatic drive(input logic v, input logic [31:0] pc, input logic [31:0] ins,
                       input logic r, input logic f);
    i_valid = v;
    i_pc    = pc;
    i_instr = ins;
    i_ready = r;
    i_flush = f;
    cycle();
  endtask

  initial begin
    logic [31:0] cur_pc;
    logic [31:0] cur_instr;

    rst_n = 1'b0;
    i_flush = 1'b0;
    i_valid = 1'b0;
    i_pc = '0;
    i_instr = '0;
    i_ready = 1'b0;
    @(posedge clk);
    #1;
    rst_n = 1'b1;

    // Fill with decode stalled, then offer a fifth entry.
    for (int k = 0; k < 4; k++) drive(1'b1, 32'h100 + 4 * k, 32'hA0 + k, 1'b0, 1'b0);
    chk("t1_count", {29'b0, o_count}, 4);
    chk("t1_ready", {31'b0, o_ready}, 0);
    chk("t1_afull", {31'b0, o_almost_full}, 1);
    chk("t1_head", o_pc, 32'h100);
    drive(1'b1, 32'h110, 32'hA4, 1'b0, 1'b0);
    chk("t1_no5th", {29'b0, o_count}, 4);

    for (int k = 0; k < 4; k++) begin
      chk("t2_pc", o_pc, 32'h100 + 4 * k);
      drive(1'b0, 32'h0, 32'h0, 1'b1, 1'b0);
    end
    chk("t2_valid", {31'b0, o_valid}, 0);
    chk("t2_pc0", o_pc, 0);
    chk("t2_instr0", o_instr, 0);
    chk("t2_count", {29'b0, o_count}, 0);

    // Steady enq+deq at occupancy 2 across a pointer wrap.
    drive(1'b1, 32'h200, 32'hB0, 1'b0, 1'b0);
    drive(1'b1, 32'h204, 32'hB1, 1'b0, 1'b0);
    for (int k = 0; k < 8; k++) begin
      chk("t3_pc", o_pc, 32'h200 + 4 * k);
      drive(1'b1, 32'h208 + 4 * k, 32'hB2 + k, 1'b1, 1'b0);
      chk("t3_count", {29'b0, o_count}, 2);
    end

    drive(1'b1, 32'h228, 32'hC0, 1'b0, 1'b0);
    drive(1'b1, 32'h22C, 32'hC1, 1'b0, 1'b0);
    chk("t4_full", {29'b0, o_count}, 4);
    drive(1'b1, 32'h300, 32'hD0, 1'b1, 1'b0);
    chk("t4_refused", {29'b0, o_count}, 3);
    drive(1'b1, 32'h300, 32'hD0, 1'b0, 1'b0);
    chk("t4_retry", {29'b0, o_count}, 4);

    drive(1'b0, 32'h0, 32'h0, 1'b1, 1'b0);
    chk("t5_pre", {29'b0, o_count}, 3);
    drive(1'b1, 32'h400, 32'hE0, 1'b1, 1'b1);
    chk("t5_count", {29'b0, o_count}, 0);
    chk("t5_valid", {31'b0, o_valid}, 0);
    drive(1'b1, 32'h500, 32'hE1, 1'b0, 1'b0);
    chk("t5_head", o_pc, 32'h500);
    chk("t5_alone", {29'b0, o_count}, 1);

    drive(1'b1, 32'h504, 32'hE2, 1'b0, 1'b0);
    chk("t6_pre", {29'b0, o_count}, 2);
    rst_n = 1'b0;
    drive(1'b0, 32'h0, 32'h0, 1'b0, 1'b0);
    rst_n = 1'b1;
    chk("t6_valid", {31'b0, o_valid}, 0);
    chk("t6_ready", {31'b0, o_ready}, 1);
    chk("t6_count", {29'b0, o_count}, 0);
    chk("t6_afull", {31'b0, o_almost_full}, 0);
    chk("t6_pc", o_pc, 0);
    chk("t6_instr", o_instr, 0);
    drive(1'b1, 32'h600, 32'hF0, 1'b0, 1'b0);
    chk("t6_head", o_pc, 32'h600);
    chk("t6_count1", {29'b0, o_count}, 1);
    for (int k = 0; k < 2; k++) drive(1'b0, 32'h0, 32'h0, 1'b1, 1'b0);

    // Random traffic: fetch holds its PC until accepted, occasional redirect and reset.
    cur_pc    = 32'h1000;
    cur_instr = $urandom;
    for (int n = 0; n < 3000; n++) begin
      rst_n   = ($urandom_range(0, 99) != 0);
      i_flush = ($urandom_range(0, 19) == 0);
      i_valid = ($urandom_range(0, 3) != 0);
      i_ready = ($urandom_range(0, 2) != 0);
      i_pc    = cur_pc;
      i_instr = cur_instr;
      cycle();
      if (!rst_n || i_flush) begin
        cur_pc    = $urandom & 32'h0000_FFFC;
        cur_instr = $urandom;
      end else if (accepted) begin
        cur_pc    = cur_pc + 32'd4;
        cur_instr = $urandom;
      end
    end
    rst_n   = 1'b1;
    i_flush = 1'b0;
    i_valid = 1'b0;
    i_ready = 1'b1;
    for (int k = 0; k < DEPTH + 1; k++) cycle();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/i_fetch_queue.md
Name: i_fetch_queue

Overview:
Instruction fetch queue directly downstream of the instruction cache; it decouples cache hit/miss timing from decode stalls.
- Each cycle the cache reports a hit (valid instruction), fetch offers that {pc, instruction} pair to this block.
- The block buffers pairs in order and presents them first-word-fall-through to decode.
- Back-pressures fetch when full; fetch holds its PC until the entry is accepted.
- Redirects (branch mispredict, jump) flush all buffered entries.

Parameters:
DEPTH, 4, number of entries; power of two, minimum 2; other values fail elaboration.
PTR_WIDTH, $clog2(DEPTH), derived localparam; pointer width.

Ports:
clk  input  1  clock
rst_n  input  1  reset, synchronous, active-low
i_flush  input  1  discard all entries (redirect)
i_valid  input  1  enqueue request (cache out.valid from the current fetch PC)
i_pc  input  `ADDR_WIDTH  byte PC of offered instruction
i_instr  input  `DATA_WIDTH  instruction word from cache
o_ready  output  1  queue can accept an entry this cycle
o_valid  output  1  head entry present for decode
o_pc  output  `ADDR_WIDTH  head PC
o_instr  output  `DATA_WIDTH  head instruction
i_ready  input  1  decode consumes head this cycle
o_count  output  PTR_WIDTH+1  current occupancy, 0..DEPTH
o_almost_full  output  1  occupancy >= DEPTH-1

Behaviour:
- State: head pointer, tail pointer (PTR_WIDTH bits each; wrap naturally modulo DEPTH), count register (PTR_WIDTH+1 bits), DEPTH-entry storage.
- Storage is not reset. Pointers and count reset to 0.
- Reset values: o_valid=0, o_ready=1, o_count=0, o_almost_full=0, o_pc=0, o_instr=0.
- Outputs are derived only from registered state:
  - o_valid = (count != 0).
  - o_ready = (count != DEPTH).
  - o_almost_full = (count >= DEPTH-1).
  - o_pc/o_instr = head entry when o_valid, else forced to 0.
- No combinational path from i_ready to o_ready, or from i_valid to o_valid.
- enq = i_valid & o_ready & ~i_flush: writes storage[tail], tail+1.
- deq = o_valid & i_ready & ~i_flush: head+1.
- count_next = count + enq - deq.
- Latency: an entry enqueued at edge N drives o_valid=1 from cycle N+1. There is no empty-queue bypass.
- Full plus simultaneous dequeue: the enqueue is still refused (o_ready=0). Fetch retries next cycle.
- Empty plus simultaneous enqueue: legal. The entry appears next cycle.
- i_valid while o_ready=0: ignored and not stored. Fetch must hold i_pc/i_instr stable and retry.
- Flush has priority over enq and deq in the same cycle.
  - Next cycle: head=tail=0, count=0, o_valid=0.
  - Any enqueue offered in the flush cycle is dropped.
  - A head presented in the flush cycle is not consumed, even if i_ready=1.
- Wrap-around: after DEPTH enqueues the tail returns to 0. Order is strictly FIFO across the wrap.
- rst_n low mid-operation clears all state on that edge, overriding flush, enq and deq.
- i_ready while o_valid=0 has no effect.
- Assertions:
  - count never exceeds DEPTH.
  - count never underflows.
  - o_pc[1:0]==0 whenever o_valid=1.

Decomposition:
- Package fetch_pkg holds:
  - typedef fetch_entry_t: packed struct {pc `ADDR_WIDTH, instr `DATA_WIDTH}.
  - constant FETCH_QUEUE_DEPTH_DEFAULT = 4.
- One sub-module, fetch_queue_ram: DEPTH x fetch_entry_t register array with one synchronous write port and one asynchronous read port. Reads by head pointer.
- Pointer and count logic stays in i_fetch_queue.

Test Plan:
1. Reset, then fill: enqueue 0x100,0x104,0x108,0x10C with instrs 0xA0..0xA3, i_ready=0.
   - After 4th edge: count=4, o_ready=0, o_almost_full=1, head o_pc=0x100.
   - A 5th offer 0x110 is not stored.
2. Drain full queue: i_ready=1 for 4 cycles, no enqueues.
   - o_pc sequence 0x100,0x104,0x108,0x10C.
   - Then o_valid=0, o_pc=0, o_instr=0, count=0.
3. Simultaneous enq/deq at count=2 over 8 cycles (PCs 0x200+4k).
   - count stays 2; order preserved across pointer wrap.
   - Output PCs 0x200..0x21C in order.
4. Full + i_ready=1 + i_valid=1 (PC 0x300).
   - Dequeue happens, enqueue refused: count 4→3.
   - 0x300 accepted next cycle; count 3→4.
5. Flush with count=3, i_valid=1 (PC 0x400), i_ready=1 in the same cycle.
   - Next cycle count=0, o_valid=0; 0x400 is absent.
   - Subsequent enqueue 0x500 appears alone at head one cycle later.
6. Assert rst_n=0 for one cycle with count=2 and i_flush=0.
   - All outputs return to reset values.
   - First post-reset enqueue 0x600 appears at head with count=1.
